// File: rtl/vc_allocator_port.sv
// Output-port downstream VC allocator: round-robin over requesting input VCs,
// hands out the lowest free downstream VC, reclaims VCs on release.
module vc_allocator_port #(
  parameter int REQ_NUM = 10,
  parameter int VC_NUM  = 2,
  parameter int VC_SIZE = $clog2(VC_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_NUM-1:0] request_i,
  input  logic [VC_NUM-1:0]  release_i,
  output logic [REQ_NUM-1:0] grant_o,
  output logic [VC_SIZE-1:0] vc_new_o,
  output logic               vc_valid_o,
  output logic [VC_NUM-1:0]  free_vc_o,
  output logic               error_o
);

  localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  logic [VC_NUM-1:0]  r_free;
  logic [PTR_W-1:0]   r_ptr;
  logic               r_error;

  logic               w_found;
  logic [PTR_W-1:0]   w_winner;
  int                 w_idx;
  logic [VC_SIZE-1:0] w_vc;
  logic               w_grant;
  logic [VC_NUM-1:0]  w_free_next;
  logic [PTR_W-1:0]   w_ptr_next;

  // Round-robin winner: first requester at or above the pointer, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 0; k < REQ_NUM; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= REQ_NUM) w_idx = w_idx - REQ_NUM;
      if (!w_found && request_i[w_idx]) begin
        w_found  = 1'b1;
        w_winner = PTR_W'(w_idx);
      end
    end
  end

  // Lowest-index free downstream VC (scan downward so the lowest wins).
  always_comb begin
    w_vc = '0;
    for (int v = VC_NUM - 1; v >= 0; v--) begin
      if (r_free[v]) w_vc = VC_SIZE'(v);
    end
  end

  // Grant outputs; suppressed while reset is asserted.
  always_comb begin
    w_grant    = w_found && (|r_free) && !rst;
    grant_o    = '0;
    vc_new_o   = '0;
    vc_valid_o = w_grant;
    if (w_grant) begin
      grant_o  = REQ_NUM'(1) << w_winner;
      vc_new_o = w_vc;
    end
  end

  // Next free bitmap and pointer. A grant only takes a free VC and a valid
  // release only returns a busy VC, so the two never touch the same bit.
  always_comb begin
    w_free_next = r_free | (release_i & ~r_free);
    w_ptr_next  = r_ptr;
    if (w_grant) begin
      w_free_next[w_vc] = 1'b0;
      w_ptr_next = (int'(w_winner) == REQ_NUM - 1) ? '0 : w_winner + PTR_W'(1);
    end
  end

  // State registers; an error flags release of an already-free VC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_free  <= '1;
      r_ptr   <= '0;
      r_error <= 1'b0;
    end else begin
      r_free  <= w_free_next;
      r_ptr   <= w_ptr_next;
      r_error <= |(release_i & r_free);
    end
  end

  assign free_vc_o = r_free;
  assign error_o   = r_error;

endmodule
